// File: rtl/param_register_file.sv
// Parametrised register file: one read/write port (A), one read-only port (B),
// registered reads with valid strobes, per-entry written tracking, bulk clear and sticky range error.
module param_register_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [WIDTH-1:0]  Data_in,
  input  logic              Clr,
  input  logic              Rd_en_b,
  input  logic [ADDR_W-1:0] Rd_addr_b,
  output logic [WIDTH-1:0]  Data_out,
  output logic              Valid_out,
  output logic              Unwritten_a,
  output logic [WIDTH-1:0]  Data_out_b,
  output logic              Valid_out_b,
  output logic              Err
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_written;

  logic [WIDTH-1:0] r_data_a;
  logic             r_valid_a;
  logic             r_unwr_a;
  logic [WIDTH-1:0] r_data_b;
  logic             r_valid_b;
  logic             r_err;

  logic w_in_range_a;
  logic w_in_range_b;
  logic w_wr_a;
  logic w_rd_a;
  logic w_zero_a;
  logic w_zero_b;
  logic w_bypass_b;

  assign w_in_range_a = ({1'b0, Address}   < LP_DEPTH);
  assign w_in_range_b = ({1'b0, Rd_addr_b} < LP_DEPTH);
  assign w_wr_a       = En & RW & w_in_range_a & ~Clr;
  assign w_rd_a       = En & ~RW;
  // Clear wins over stored data; out-of-range reads also return zero
  assign w_zero_a     = Clr | ~w_in_range_a;
  assign w_zero_b     = Clr | ~w_in_range_b;
  assign w_bypass_b   = w_wr_a & (Address == Rd_addr_b);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_written <= '0;
    end else if (Clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_written <= '0;
    end else if (w_wr_a) begin
      r_mem[Address]     <= Data_in;
      r_written[Address] <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_data_a  <= '0;
      r_unwr_a  <= 1'b0;
      r_valid_a <= 1'b0;
    end else begin
      r_valid_a <= w_rd_a;
      if (w_rd_a) begin
        r_data_a <= w_zero_a ? '0 : r_mem[Address];
        r_unwr_a <= w_zero_a | ~r_written[Address];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_data_b  <= '0;
      r_valid_b <= 1'b0;
    end else begin
      r_valid_b <= Rd_en_b;
      if (Rd_en_b) begin
        if (w_zero_b)        r_data_b <= '0;
        else if (w_bypass_b) r_data_b <= Data_in;
        else                 r_data_b <= r_mem[Rd_addr_b];
      end
    end
  end

  // Sticky until reset; Clr deliberately leaves it alone
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      r_err <= 1'b0;
    else if ((En & ~w_in_range_a) | (Rd_en_b & ~w_in_range_b))
      r_err <= 1'b1;
  end

  assign Data_out    = r_data_a;
  assign Valid_out   = r_valid_a;
  assign Unwritten_a = r_unwr_a;
  assign Data_out_b  = r_data_b;
  assign Valid_out_b = r_valid_b;
  assign Err         = r_err;

endmodule
